// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe
// Pipelined floating-point compare unit (FEQ / FLT / FLE) with RISC-V NaN
// and invalid-flag semantics, parametrised for any IEEE-style width.
// Two register stages with valid/ready handshaking and full backpressure.
// Each result carries the opaque tag of its operation.
//
// Optional feature macro: FP_MINMAX_EN
//   Defined   -> ops 100 (FMIN) and 101 (FMAX) are implemented.
//   Undefined -> those ops behave as unlisted op codes (result 0, nv 0).
//
// Ports:
//   clk, resetn            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready    operation handshake
//   in_op                  000 FLE, 001 FLT, 010 FEQ, 100 FMIN, 101 FMAX
//   in_rs1, in_rs2         operands a and b (FLEN bits)
//   in_tag                 tag returned unchanged with the result
//   out_valid / out_ready  result handshake
//   out_result             result, zero-extended to XLEN
//   out_nv                 invalid-operation flag for this result
//   out_tag                tag of this result
//   nv_sticky              accumulated invalid flag
//   flag_clr               synchronous clear of nv_sticky
module fp_compare_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    localparam int FLEN = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [FLEN-1:0]  in_rs1,
    input  logic [FLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_nv,
    output logic [TAG_W-1:0] out_tag,
    output logic             nv_sticky,
    input  logic             flag_clr
);

    localparam logic [2:0] OP_FLE  = 3'b000;
    localparam logic [2:0] OP_FLT  = 3'b001;
    localparam logic [2:0] OP_FEQ  = 3'b010;
`ifdef FP_MINMAX_EN
    localparam logic [2:0] OP_FMIN = 3'b100;
    localparam logic [2:0] OP_FMAX = 3'b101;
`endif

    function automatic logic is_nan(input logic [FLEN-1:0] x);
        return (&x[FLEN-2:MAN_W]) && (|x[MAN_W-1:0]);
    endfunction

    function automatic logic is_snan(input logic [FLEN-1:0] x);
        return is_nan(x) && !x[MAN_W-1];
    endfunction

    function automatic logic is_zero(input logic [FLEN-1:0] x);
        return ~|x[FLEN-2:0];
    endfunction

    // Stage-1 state
    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_a_nan, s1_b_nan, s1_a_snan, s1_b_snan;
    logic             s1_both_zero;
    logic             s1_raw_lt, s1_raw_eq;
`ifdef FP_MINMAX_EN
    logic [FLEN-1:0]  s1_a, s1_b;
`endif

    // Handshake
    logic s2_free, s1_adv, accept;

    assign s2_free  = ~out_valid | out_ready;
    assign s1_adv   = s1_valid & s2_free;
    assign in_ready = ~s1_valid | s2_free;
    assign accept   = in_valid & in_ready;

    // Raw sign-magnitude ordering: -0 sorts below +0 here, which is what
    // min/max wants; the compare ops fold zeros together in stage 2.
    logic raw_lt;

    always_comb begin
        raw_lt = 1'b0;
        if (in_rs1[FLEN-1] != in_rs2[FLEN-1])
            raw_lt = in_rs1[FLEN-1];
        else if (in_rs1[FLEN-1])
            raw_lt = in_rs1[FLEN-2:0] > in_rs2[FLEN-2:0];
        else
            raw_lt = in_rs1[FLEN-2:0] < in_rs2[FLEN-2:0];
    end

    // Stage 1: register op, tag, classification and magnitude compare
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid     <= 1'b0;
            s1_op        <= '0;
            s1_tag       <= '0;
            s1_a_nan     <= 1'b0;
            s1_b_nan     <= 1'b0;
            s1_a_snan    <= 1'b0;
            s1_b_snan    <= 1'b0;
            s1_both_zero <= 1'b0;
            s1_raw_lt    <= 1'b0;
            s1_raw_eq    <= 1'b0;
`ifdef FP_MINMAX_EN
            s1_a         <= '0;
            s1_b         <= '0;
`endif
        end else if (accept) begin
            s1_valid     <= 1'b1;
            s1_op        <= in_op;
            s1_tag       <= in_tag;
            s1_a_nan     <= is_nan(in_rs1);
            s1_b_nan     <= is_nan(in_rs2);
            s1_a_snan    <= is_snan(in_rs1);
            s1_b_snan    <= is_snan(in_rs2);
            s1_both_zero <= is_zero(in_rs1) && is_zero(in_rs2);
            s1_raw_lt    <= raw_lt;
            s1_raw_eq    <= in_rs1 == in_rs2;
`ifdef FP_MINMAX_EN
            s1_a         <= in_rs1;
            s1_b         <= in_rs2;
`endif
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage-2 result logic
    logic            any_nan, any_snan, ieee_lt, ieee_eq;
    logic [XLEN-1:0] nxt_result;
    logic            nxt_nv;

    assign any_nan  = s1_a_nan | s1_b_nan;
    assign any_snan = s1_a_snan | s1_b_snan;
    assign ieee_lt  = s1_raw_lt & ~s1_both_zero;
    assign ieee_eq  = s1_raw_eq | s1_both_zero;

`ifdef FP_MINMAX_EN
    logic [FLEN-1:0] canon_nan;

    always_comb begin
        canon_nan              = '0;
        canon_nan[FLEN-2:MAN_W] = '1;
        canon_nan[MAN_W-1]     = 1'b1;
    end
`endif

    always_comb begin
        nxt_result = '0;
        nxt_nv     = 1'b0;
        case (s1_op)
            OP_FLE: begin
                nxt_result[0] = ~any_nan & (ieee_lt | ieee_eq);
                nxt_nv        = any_nan;
            end
            OP_FLT: begin
                nxt_result[0] = ~any_nan & ieee_lt;
                nxt_nv        = any_nan;
            end
            OP_FEQ: begin
                nxt_result[0] = ~any_nan & ieee_eq;
                nxt_nv        = any_snan;
            end
`ifdef FP_MINMAX_EN
            OP_FMIN, OP_FMAX: begin
                nxt_nv = any_snan;
                // Picks a when (FMIN and a<b) or (FMAX and not a<b)
                if (s1_a_nan && s1_b_nan)
                    nxt_result[FLEN-1:0] = canon_nan;
                else if (s1_a_nan)
                    nxt_result[FLEN-1:0] = s1_b;
                else if (s1_b_nan)
                    nxt_result[FLEN-1:0] = s1_a;
                else if ((s1_op == OP_FMIN) == s1_raw_lt)
                    nxt_result[FLEN-1:0] = s1_a;
                else
                    nxt_result[FLEN-1:0] = s1_b;
            end
`endif
            default: begin
                nxt_result = '0;
                nxt_nv     = 1'b0;
            end
        endcase
    end

    // Stage 2: output registers, held while the consumer stalls
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_nv     <= 1'b0;
            out_tag    <= '0;
        end else if (s1_adv) begin
            out_valid  <= 1'b1;
            out_result <= nxt_result;
            out_nv     <= nxt_nv;
            out_tag    <= s1_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky invalid flag; a flagged transfer overrides a coincident clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            nv_sticky <= 1'b0;
        else if (out_valid && out_ready && out_nv)
            nv_sticky <= 1'b1;
        else if (flag_clr)
            nv_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// tb_fp_compare_pipe
// Directed bench for fp_compare_pipe at default parameters. Expected results
// are queued when an operation is accepted and compared, in order, when the
// DUT hands a result over. Min/max checks build only with FP_MINMAX_EN.
module tb_fp_compare_pipe;

    typedef struct {
        logic [31:0] res;
        logic        nv;
        logic [4:0]  tag;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_nv;
    logic [4:0]  out_tag;
    logic        nv_sticky;
    logic        flag_clr;

    exp_t sb[$];
    int   checkCount = 0;
    int   passCount  = 0;

    fp_compare_pipe dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_nv     (out_nv),
        .out_tag    (out_tag),
        .nv_sticky  (nv_sticky),
        .flag_clr   (flag_clr)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net against a hung handshake
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed 0x%08h required 0x%08h", name, obs, exp);
    endtask

    // Drive one op from a negedge, wait (bounded) for acceptance, queue its expectation
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag, input logic [31:0] expRes, input logic expNv);
        int n = 0;
        exp_t e;
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
        if (in_ready) begin
            e.res = expRes;
            e.nv  = expNv;
            e.tag = tag;
            sb.push_back(e);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", sb.size(), 32'd0);
    endtask

    // Scoreboard: a transfer pending at the next posedge is checked here
    always @(negedge clk) begin
        #2;
        if (resetn && out_valid && out_ready) begin
            checkCount++;
            assert (sb.size() > 0) passCount++;
            else $error("[TB] FAIL unexpected_output: observed tag %0d, required no output", out_tag);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checkOutput($sformatf("result_tag%0d", e.tag), out_result, e.res);
                checkOutput($sformatf("nv_tag%0d", e.tag), {31'b0, out_nv}, {31'b0, e.nv});
                checkOutput($sformatf("tag_tag%0d", e.tag), {27'b0, out_tag}, {27'b0, e.tag});
            end
        end
    end

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        flag_clr  = 1'b0;
        #3;
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_out_result", out_result, 32'd0);
        checkOutput("reset_out_tag", {27'b0, out_tag}, 32'd0);
        checkOutput("reset_nv_sticky", {31'b0, nv_sticky}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

        // Latency of the first op
        applyStimulus(3'b010, 32'h3F800000, 32'h3F800000, 5'd9, 32'd1, 1'b0);
        checkOutput("latency_not_yet", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("latency_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("latency_tag", {27'b0, out_tag}, 32'd9);
        waitDrain();

        // Basic compares and zero signs, back to back
        applyStimulus(3'b001, 32'hC0000000, 32'hBF800000, 5'd1, 32'd1, 1'b0);
        applyStimulus(3'b000, 32'h3F800000, 32'hBF800000, 5'd2, 32'd0, 1'b0);
        applyStimulus(3'b010, 32'h00000000, 32'h80000000, 5'd3, 32'd1, 1'b0);
        applyStimulus(3'b001, 32'h00000000, 32'h80000000, 5'd4, 32'd0, 1'b0);
        applyStimulus(3'b000, 32'h00000000, 32'h80000000, 5'd5, 32'd1, 1'b0);
        applyStimulus(3'b011, 32'h3F800000, 32'h3F800000, 5'd6, 32'd0, 1'b0);
        waitDrain();
        checkOutput("sticky_still_clear", {31'b0, nv_sticky}, 32'd0);

        // NaN rules
        applyStimulus(3'b010, 32'h7FC00000, 32'h7FC00000, 5'd10, 32'd0, 1'b0);
        applyStimulus(3'b010, 32'h7F800001, 32'h3F800000, 5'd11, 32'd0, 1'b1);
        applyStimulus(3'b001, 32'h7FC00000, 32'h3F800000, 5'd12, 32'd0, 1'b1);
        waitDrain();
        checkOutput("sticky_set", {31'b0, nv_sticky}, 32'd1);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        checkOutput("sticky_cleared", {31'b0, nv_sticky}, 32'd0);

        // Clear coincident with a flagged transfer
        applyStimulus(3'b001, 32'h7FC00000, 32'h3F800000, 5'd13, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("coincident_valid", {31'b0, out_valid}, 32'd1);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        checkOutput("sticky_set_wins", {31'b0, nv_sticky}, 32'd1);
        waitDrain();

`ifdef FP_MINMAX_EN
        applyStimulus(3'b100, 32'h80000000, 32'h00000000, 5'd14, 32'h80000000, 1'b0);
        applyStimulus(3'b101, 32'h7FC00000, 32'h40000000, 5'd15, 32'h40000000, 1'b0);
        applyStimulus(3'b100, 32'h7F800001, 32'h7FC00000, 5'd16, 32'h7FC00000, 1'b1);
        applyStimulus(3'b101, 32'hBF800000, 32'hC0000000, 5'd17, 32'hBF800000, 1'b0);
`else
        applyStimulus(3'b100, 32'h7F800001, 32'h3F800000, 5'd14, 32'd0, 1'b0);
        applyStimulus(3'b101, 32'h80000000, 32'h00000000, 5'd15, 32'd0, 1'b0);
`endif
        waitDrain();

        // Backpressure: four ops with the consumer stalled for five cycles
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(3'b010, 32'h3F800000, 32'h3F800000, 5'd1, 32'd1, 1'b0);
                applyStimulus(3'b001, 32'h3F800000, 32'h40000000, 5'd2, 32'd1, 1'b0);
                applyStimulus(3'b000, 32'h40000000, 32'h3F800000, 5'd3, 32'd0, 1'b0);
                applyStimulus(3'b001, 32'hBF800000, 32'h3F800000, 5'd4, 32'd1, 1'b0);
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
                    checkOutput("stall_out_valid", {31'b0, out_valid}, 32'd1);
                    checkOutput("stall_out_tag", {27'b0, out_tag}, 32'd1);
                    checkOutput("stall_out_result", out_result, 32'd1);
                    @(negedge clk);
                end
                out_ready = 1'b1;
                for (int i = 1; i <= 4; i++) begin
                    checkOutput("release_valid", {31'b0, out_valid}, 32'd1);
                    checkOutput("release_order", {27'b0, out_tag}, i);
                    @(negedge clk);
                end
            end
        join
        waitDrain();

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        applyStimulus(3'b001, 32'h7FC00000, 32'h3F800000, 5'd20, 32'd0, 1'b1);
        applyStimulus(3'b010, 32'h3F800000, 32'h3F800000, 5'd21, 32'd1, 1'b0);
        checkOutput("full_out_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("full_in_ready", {31'b0, in_ready}, 32'd0);
        #3;
        resetn = 1'b0;
        #1;
        checkOutput("async_reset_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("async_reset_sticky", {31'b0, nv_sticky}, 32'd0);
        checkOutput("async_reset_tag", {27'b0, out_tag}, 32'd0);
        sb.delete();
        @(negedge clk);
        resetn    = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("no_stale_result", {31'b0, out_valid}, 32'd0);
        end
        checkOutput("ready_after_mid_reset", {31'b0, in_ready}, 32'd1);

        // Pipeline still works after the mid-operation reset
        applyStimulus(3'b000, 32'hC0000000, 32'hC0000000, 5'd22, 32'd1, 1'b0);
        waitDrain();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
